// File: rtl/store_merge_unit_if.sv
// Store request and data-memory port bundle for store_merge_unit.
// slave  : the store merge unit (takes requests, drives the memory port)
// master : the environment (CPU datapath issuing stores, memory answering)
interface store_merge_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  store_valid;
    logic                  store_ready;
    logic [2:0]            store_type;
    logic [ADDR_WIDTH-1:0] store_addr;
    logic [31:0]           store_data;
    logic                  store_done;
    logic                  store_err;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           mem_writedata;
    logic [3:0]            mem_byteenable;
    logic [31:0]           mem_readdata;
    logic                  mem_waitrequest;

    modport slave (
        input  store_valid, store_type, store_addr, store_data,
        input  mem_readdata, mem_waitrequest,
        output store_ready, store_done, store_err,
        output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable
    );

    modport master (
        output store_valid, store_type, store_addr, store_data,
        output mem_readdata, mem_waitrequest,
        input  store_ready, store_done, store_err,
        input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable
    );
endinterface

// File: rtl/store_merge_unit.sv
// store_merge_unit: turns SB/SH/SW/SWL/SWR requests into word-aligned
// Avalon-style memory writes. Default build does read-modify-write with all
// four byte lanes enabled. Defining STORE_BYTEENABLE_EN skips the read and
// writes the lane-replicated data with per-lane byte enables instead.
module store_merge_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    store_merge_unit_if.slave  bus
);
    localparam int DATA_W = 32;

    localparam logic [2:0] T_SB  = 3'b000;
    localparam logic [2:0] T_SH  = 3'b001;
    localparam logic [2:0] T_SW  = 3'b010;
    localparam logic [2:0] T_SWL = 3'b011;
    localparam logic [2:0] T_SWR = 3'b100;

    typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic [2:0]            type_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  err_q;
    logic [1:0]            ofs_q;
`ifndef STORE_BYTEENABLE_EN
    logic [DATA_W-1:0]     merged_q;
`endif

    // Misaligned halfword/word or an unknown type is rejected at accept.
    function automatic logic type_err(input logic [2:0] t, input logic [1:0] o);
        case (t)
            T_SB, T_SWL, T_SWR: type_err = 1'b0;
            T_SH:               type_err = o[0];
            T_SW:               type_err = |o;
            default:            type_err = 1'b1;
        endcase
    endfunction

    // Byte lanes touched by the store at byte offset o.
    function automatic logic [3:0] lane_enable(input logic [2:0] t, input logic [1:0] o);
        case (t)
            T_SB:    lane_enable = 4'b0001 << o;
            T_SH:    lane_enable = 4'b0011 << o;
            T_SW:    lane_enable = 4'b1111;
            T_SWL:   lane_enable = 4'b1111 >> (2'd3 - o);
            T_SWR:   lane_enable = 4'b1111 << o;
            default: lane_enable = 4'b0000;
        endcase
    endfunction

    // Register data steered so every enabled lane already holds its byte.
    function automatic logic [DATA_W-1:0] lane_data(input logic [2:0] t, input logic [1:0] o,
                                                    input logic [DATA_W-1:0] r);
        case (t)
            T_SB:    lane_data = {4{r[7:0]}};
            T_SH:    lane_data = {2{r[15:0]}};
            T_SW:    lane_data = r;
            T_SWL:   lane_data = r >> (5'd24 - {o, 3'b000});
            T_SWR:   lane_data = r << {o, 3'b000};
            default: lane_data = '0;
        endcase
    endfunction

    // Expand a 4-bit lane enable into a 32-bit bit mask.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [3:0] be);
        lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    assign accept = bus.store_valid && (state == IDLE);
    assign ofs_q  = addr_q[1:0];

    // FSM state register; only control state is reset.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Capture the request on accept so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            type_q <= bus.store_type;
            addr_q <= bus.store_addr;
            data_q <= bus.store_data;
            err_q  <= type_err(bus.store_type, bus.store_addr[1:0]);
        end
    end

`ifndef STORE_BYTEENABLE_EN
    // Merge the returned old word with the store lanes while in LATCH.
    always_ff @(posedge clk) begin
        if (state == LATCH) begin
            merged_q <= (lane_data(type_q, ofs_q, data_q) & lane_mask(lane_enable(type_q, ofs_q)))
                      | (bus.mem_readdata & ~lane_mask(lane_enable(type_q, ofs_q)));
        end
    end
`endif

    // Next-state and Moore outputs; strobes derive from state so reset clears them.
    always_comb begin
        state_nxt          = state;
        bus.store_ready    = 1'b0;
        bus.store_done     = 1'b0;
        bus.store_err      = 1'b0;
        bus.mem_address    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_writedata  = '0;
        bus.mem_byteenable = 4'b0000;
        case (state)
            IDLE: begin
                bus.store_ready = 1'b1;
                if (accept) begin
                    if (type_err(bus.store_type, bus.store_addr[1:0])) begin
                        state_nxt = DONE;
                    end else begin
`ifdef STORE_BYTEENABLE_EN
                        state_nxt = WRITE;
`else
                        state_nxt = READ;
`endif
                    end
                end
            end
            READ: begin
                bus.mem_read = 1'b1;
                if (!bus.mem_waitrequest) state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                bus.mem_write = 1'b1;
`ifdef STORE_BYTEENABLE_EN
                bus.mem_writedata  = lane_data(type_q, ofs_q, data_q);
                bus.mem_byteenable = lane_enable(type_q, ofs_q);
`else
                bus.mem_writedata  = merged_q;
                bus.mem_byteenable = 4'b1111;
`endif
                if (!bus.mem_waitrequest) state_nxt = DONE;
            end
            DONE: begin
                bus.store_done = 1'b1;
                bus.store_err  = err_q;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: directed cases plus randomized
// stores against a byte-level reference model and a small memory model.
`timescale 1ns/1ps
module tb_store_merge_unit;
    localparam int AW = 32;
`ifdef STORE_BYTEENABLE_EN
    localparam bit BE_MODE = 1'b1;
`else
    localparam bit BE_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_merge_unit_if #(.ADDR_WIDTH(AW)) bus();

    store_merge_unit #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [256];
    int          rd_left = 0;
    int          wr_left = 0;
    int          n_reads = 0;
    int          n_writes = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wd = '0;
    logic [3:0]  exp_be = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: memory word after the store, built byte by byte.
    function automatic logic [31:0] ref_after(input logic [2:0] t, input logic [1:0] o,
                                              input logic [31:0] r, input logic [31:0] m);
        logic [7:0] b [4];
        int oi;
        oi = int'(o);
        for (int k = 0; k < 4; k++) b[k] = m[8*k +: 8];
        case (t)
            3'd0: b[oi] = r[7:0];
            3'd1: begin b[oi] = r[7:0]; b[oi+1] = r[15:8]; end
            3'd2: for (int k = 0; k < 4; k++) b[k] = r[8*k +: 8];
            3'd3: for (int k = 0; k <= oi; k++) b[k] = r[8*(k+3-oi) +: 8];
            3'd4: for (int k = oi; k < 4; k++) b[k] = r[8*(k-oi) +: 8];
            default: ;
        endcase
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] t, input logic [1:0] o);
        logic [3:0] be;
        int oi;
        oi = int'(o);
        be = '0;
        for (int k = 0; k < 4; k++)
            be[k] = (t == 3'd0 && k == oi) || (t == 3'd1 && (k == oi || k == oi + 1)) ||
                    (t == 3'd2) || (t == 3'd3 && k <= oi) || (t == 3'd4 && k >= oi);
        return be;
    endfunction

    // Write word with data copied into lanes (byte-enable build).
    function automatic logic [31:0] ref_rep(input logic [2:0] t, input logic [1:0] o,
                                            input logic [31:0] r);
        logic [31:0] w;
        int oi;
        oi = int'(o);
        w = '0;
        for (int k = 0; k < 4; k++) begin
            case (t)
                3'd0: w[8*k +: 8] = r[7:0];
                3'd1: w[8*k +: 8] = r[8*(k%2) +: 8];
                3'd2: w[8*k +: 8] = r[8*k +: 8];
                3'd3: if (k <= oi) w[8*k +: 8] = r[8*(k+3-oi) +: 8];
                3'd4: if (k >= oi) w[8*k +: 8] = r[8*(k-oi) +: 8];
                default: ;
            endcase
        end
        return w;
    endfunction

    function automatic bit ref_err(input logic [2:0] t, input logic [1:0] o);
        return (t > 3'd4) || (t == 3'd1 && o[0]) || (t == 3'd2 && o != 2'd0);
    endfunction

    // Memory model: answers on the falling edge, checks the port while active.
    always @(negedge clk) begin
        check_eq("rw_excl", {31'b0, bus.mem_read & bus.mem_write}, 32'd0);
        bus.mem_waitrequest = 1'b0;
        if (bus.mem_read) begin
            check_eq("rd_addr", bus.mem_address, exp_addr);
            if (rd_left > 0) begin
                bus.mem_waitrequest = 1'b1;
                rd_left--;
            end else begin
                bus.mem_readdata = mem[bus.mem_address[9:2]];
                n_reads++;
            end
        end else if (bus.mem_write) begin
            check_eq("wr_addr", bus.mem_address, exp_addr);
            check_eq("wr_data", bus.mem_writedata, exp_wd);
            check_eq("wr_be", {28'b0, bus.mem_byteenable}, {28'b0, exp_be});
            if (wr_left > 0) begin
                bus.mem_waitrequest = 1'b1;
                wr_left--;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (bus.mem_byteenable[k])
                        mem[bus.mem_address[9:2]][8*k +: 8] = bus.mem_writedata[8*k +: 8];
                n_writes++;
            end
        end
    end

    task automatic do_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                            input int rw, input int ww);
        logic [1:0]  o;
        logic [31:0] exp_word;
        bit          e;
        bit          seen;
        int          lat;
        int          cyc;
        int          r0;
        int          w0;
        o        = a[1:0];
        e        = ref_err(t, o);
        exp_word = e ? mem[a[9:2]] : ref_after(t, o, d, mem[a[9:2]]);
        exp_addr = {a[31:2], 2'b00};
        exp_wd   = BE_MODE ? ref_rep(t, o, d) : exp_word;
        exp_be   = BE_MODE ? ref_be(t, o) : 4'b1111;
        rd_left  = BE_MODE ? 0 : rw;
        wr_left  = ww;
        lat      = e ? 1 : (BE_MODE ? 2 + ww : 4 + rw + ww);
        r0       = n_reads;
        w0       = n_writes;
        @(negedge clk);
        check_eq("ready", {31'b0, bus.store_ready}, 32'd1);
        bus.store_valid = 1'b1;
        bus.store_type  = t;
        bus.store_addr  = a;
        bus.store_data  = d;
        @(posedge clk);
        #1;
        bus.store_valid = 1'b0;
        bus.store_type  = 3'($urandom);
        bus.store_addr  = $urandom;
        bus.store_data  = $urandom;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.store_done) seen = 1'b1;
        end
        check_eq("done_seen", {31'b0, seen}, 32'd1);
        check_eq("latency", cyc, lat);
        check_eq("err", {31'b0, bus.store_err}, {31'b0, e});
        check_eq("n_reads", n_reads - r0, (e || BE_MODE) ? 0 : 1);
        check_eq("n_writes", n_writes - w0, e ? 0 : 1);
        check_eq("mem_word", mem[a[9:2]], exp_word);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic [2:0] rt;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        reset           = 1'b1;
        bus.store_valid = 1'b0;
        bus.store_type  = '0;
        bus.store_addr  = '0;
        bus.store_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'b0, bus.store_ready}, 32'd1);
        check_eq("rst_done", {31'b0, bus.store_done}, 32'd0);
        check_eq("rst_err", {31'b0, bus.store_err}, 32'd0);
        check_eq("rst_rd", {31'b0, bus.mem_read}, 32'd0);
        check_eq("rst_wr", {31'b0, bus.mem_write}, 32'd0);
        check_eq("rst_wd", bus.mem_writedata, 32'd0);
        check_eq("rst_be", {28'b0, bus.mem_byteenable}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        mem[8'h40] = 32'h11223344;
        do_store(3'd2, 32'h100, 32'hDEADBEEF, 0, 0);
        mem[8'h40] = 32'h11223344;
        do_store(3'd0, 32'h102, 32'h000000AB, 0, 0);
        mem[8'h80] = 32'h11223344;
        do_store(3'd3, 32'h201, 32'hAABBCCDD, 0, 0);
        mem[8'h80] = 32'h11223344;
        do_store(3'd4, 32'h201, 32'hAABBCCDD, 0, 0);
        mem[8'h80] = 32'h11223344;
        do_store(3'd3, 32'h203, 32'hAABBCCDD, 0, 0);
        mem[8'h80] = 32'h11223344;
        do_store(3'd4, 32'h200, 32'hAABBCCDD, 0, 0);
        do_store(3'd1, 32'h103, 32'h12345678, 0, 0);
        do_store(3'd6, 32'h100, 32'h12345678, 0, 0);
        do_store(3'd2, 32'h102, 32'h12345678, 0, 0);
        mem[8'h40] = 32'h11223344;
        do_store(3'd1, 32'h102, 32'h0000BEEF, 0, 0);
        mem[8'h40] = 32'h11223344;
        do_store(3'd2, 32'h100, 32'hCAFEF00D, 3, 2);

        // Reset while a write is stalled
        mem[8'h40] = 32'h55667788;
        exp_addr = 32'h100;
        exp_wd   = 32'h0BADF00D;
        exp_be   = 4'b1111;
        rd_left  = 0;
        wr_left  = 1000;
        @(negedge clk);
        bus.store_valid = 1'b1;
        bus.store_type  = 3'd2;
        bus.store_addr  = 32'h100;
        bus.store_data  = 32'h0BADF00D;
        @(posedge clk);
        #1;
        bus.store_valid = 1'b0;
        cyc = 0;
        while (!bus.mem_write && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_in_write", {31'b0, bus.mem_write}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_wr", {31'b0, bus.mem_write}, 32'd0);
        check_eq("rst_mid_rd", {31'b0, bus.mem_read}, 32'd0);
        check_eq("rst_mid_ready", {31'b0, bus.store_ready}, 32'd1);
        check_eq("rst_mid_done", {31'b0, bus.store_done}, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        wr_left = 0;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_no_done", {31'b0, bus.store_done}, 32'd0);
        end
        check_eq("rst_mem_kept", mem[8'h40], 32'h55667788);
        do_store(3'd0, 32'h101, 32'h000000C3, 0, 0);

        // Randomized stores, mostly valid types
        for (int i = 0; i < 60; i++) begin
            rt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            do_store(rt, 32'($urandom_range(0, 1023)), $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart of the load left/right merge path: takes SB/SH/SW/SWL/SWR requests from the CPU datapath and produces word-aligned memory writes.
- Sits between the execute/memory stage and the Avalon-style data memory port.
- By default performs read-modify-write so only the addressed bytes change. Lane merging uses the same byte-lane rules as the load-side merge.

Parameters:
ADDR_WIDTH, 32, width of store_addr and mem_address

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
store_valid  input  1  request present
store_ready  output  1  high only in IDLE; request accepted when store_valid && store_ready
store_type  input  3  000 SB, 001 SH, 010 SW, 011 SWL, 100 SWR, 101-111 invalid
store_addr  input  ADDR_WIDTH  byte address
store_data  input  32  rt register value
store_done  output  1  one-cycle pulse at completion
store_err  output  1  valid with store_done; 1 = misaligned or invalid type, memory untouched
mem_address  output  ADDR_WIDTH  word address, {addr[ADDR_WIDTH-1:2],2'b00}
mem_read  output  1  read strobe
mem_write  output  1  write strobe
mem_writedata  output  32  write word
mem_byteenable  output  4  byte lane enables
mem_readdata  input  32  read word, valid the cycle after mem_read && !mem_waitrequest
mem_waitrequest  input  1  memory stall

Behaviour:
- Byte ordering is little-endian: byte k = bits [8k+7:8k]. o = store_addr[1:0].
- On accept, register store_type, store_addr and store_data. Later changes on the inputs are ignored.
- Reset:
  - state goes to IDLE.
  - store_ready=1.
  - store_done, store_err, mem_read and mem_write are 0.
  - mem_writedata and mem_byteenable are 0.
  - Reset mid-operation abandons the store. The strobes drop in the cycle after the reset edge, and no done pulse is issued.
- Error check, done at accept:
  - Invalid type → error.
  - SH with o[0]=1 → error.
  - SW with o!=0 → error.
  - SB, SWL and SWR never raise alignment errors.
  - On error go to DONE with store_err=1 and issue no memory access.
- Lane merge (M = old memory word, R = store_data):
  - SB: byte o = R[7:0].
  - SH: bytes o,o+1 = R[15:0].
  - SW: word = R.
  - SWL: bytes o..0 = R[31:24-8o]. Word = {M[31:8(o+1)], R[31:24-8o]}; o=3 gives R.
  - SWR: bytes 3..o = R[31-8o:0]. Word = {R[31-8o:0], M[8o-1:0]}; o=0 gives R.
  - Lane enables: SB 0001<<o. SH 0011<<o. SW 1111. SWL (1<<(o+1))-1. SWR 1111<<o (4-bit truncated).
- FSM: IDLE → READ → LATCH → WRITE → DONE → IDLE.
  - READ: mem_read=1. Hold while mem_waitrequest.
  - LATCH: capture mem_readdata and form the merged word.
  - WRITE: mem_write=1, mem_byteenable=1111, mem_writedata=merged word. Hold while mem_waitrequest.
  - DONE: store_done=1 for one cycle.
- mem_read and mem_write are never high together. mem_address is stable throughout READ..WRITE.
- Zero-wait latency: accept at cycle 0, READ cycle 1, LATCH cycle 2, WRITE cycle 3, store_done cycle 4. Each waitrequest cycle adds one.
- Error latency: store_done and store_err in cycle 1.
- Back-to-back: a new request can be accepted in the cycle after DONE (IDLE).

Optional Feature:
- Macro: STORE_BYTEENABLE_EN.
- Defined: READ and LATCH are skipped (IDLE → WRITE).
  - mem_writedata = R replicated into lanes: SB {4{R[7:0]}}; SH {2{R[15:0]}}; SWL R>>(24-8o); SWR R<<8o.
  - mem_byteenable comes from the lane-enable table. mem_read is never asserted.
  - Zero-wait latency is 2 cycles (WRITE cycle 1, done cycle 2).
- Undefined: RMW behaviour as above, with byteenable fixed at 1111.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, old word 0x11223344, no waits → one write of 0xDEADBEEF to 0x100; done at cycle 4; err=0 (with macro: be=1111, done cycle 2).
- SB addr 0x102, data 0x000000AB, old 0x11223344 → write 0x11AB3344 (with macro: writedata 0xABABABAB, be=0100).
- SWL addr 0x201, data 0xAABBCCDD, old 0x11223344 → write 0x1122AABB. SWR addr 0x201 same data/old → write 0xBBCCDD44.
- SH addr 0x103 → store_err=1 and store_done in cycle 1, no mem_read/mem_write. Same for store_type 110.
- SW with 3 waitrequest cycles in READ and 2 in WRITE → done at cycle 9. Address and writedata held stable while stalled.
- Assert reset during WRITE with waitrequest high → strobes low the next cycle, store_ready=1, no store_done. A following SB completes normally.
